axi4_lite_dual_master: RTL and testbench
========================================

AXI4_LITE_DUAL_MASTER -- requirements
Module: axi4_lite_dual_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; legal values are 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (reset==0 resets on the next clk edge).
REQ-005 instr_req_o  input  1  instruction fetch request; held until instr_gnt_i.
REQ-006 instr_addr  input  ADDR_WIDTH  fetch address.
REQ-007 instr_gnt_i  output  1  one-cycle instruction grant.
REQ-008 instr_rvalid_i  output  1  one-cycle fetch completion.
REQ-009 data_req_o  input  1  data request; held until data_gnt_i.
REQ-010 data_we_o  input  1  1=write, 0=read.
REQ-011 data_be  input  DATA_WIDTH/8  write byte enables.
REQ-012 data_addr  input  ADDR_WIDTH  data address.
REQ-013 data_wdata  input  DATA_WIDTH  write data.
REQ-014 data_gnt_i  output  1  one-cycle data grant.
REQ-015 data_rvalid_i  output  1  one-cycle data read or write completion.
REQ-016 Read_Data  output  DATA_WIDTH  read data; held until next read completion.
REQ-017 rsp_err  output  1  completion error; valid with either rvalid.
REQ-018 AWvalid/AWready/AWaddr  output/input/output  1/1/ADDR_WIDTH  AXI write address channel.
REQ-019 Wvalid/Wready/Wdata/Wstrb  output/input/output/output  1/1/DATA_WIDTH/DATA_WIDTH/8  AXI write data channel.
REQ-020 Bvalid/Bready/Bresp  input/output/input  1/1/2  AXI write response channel.
REQ-021 ARvalid/ARready/ARaddr  output/input/output  1/1/ADDR_WIDTH  AXI read address channel.
REQ-022 Rvalid/Rready/Rdata/Rresp  input/output/input/input  1/1/DATA_WIDTH/2  AXI read data channel.

Function
REQ-023 SHALL implement states IDLE, AR_WAIT, R_WAIT, WR_WAIT, B_WAIT, with one outstanding transaction at a time.
REQ-024 In IDLE, a pending request SHALL be granted: gnt is asserted combinationally that cycle, and address/data/be/we/source are captured at that edge.
REQ-025 Simultaneous requests SHALL be arbitrated round-robin: the source not served last wins; after reset, instruction has priority.
REQ-026 Granted read (instr, or data with we=0): next cycle AR_WAIT, ARvalid=1; ARaddr stays stable until ARready; then R_WAIT with Rready=1.
REQ-027 In R_WAIT on Rvalid: Read_Data<=Rdata, pulse the source's rvalid for one cycle, rsp_err<=(Rresp!=2'b00), return to IDLE.
REQ-028 Granted write: next cycle WR_WAIT with AWvalid=Wvalid=1, Wstrb=captured data_be; each valid drops independently after its own handshake; go to B_WAIT when both have completed (same-cycle completion allowed).
REQ-029 In B_WAIT, Bready=1; on Bvalid: pulse data_rvalid_i, rsp_err<=(Bresp!=2'b00), Read_Data unchanged, return to IDLE.
REQ-030 Valids SHALL NOT depend combinationally on readies; payloads SHALL stay stable while valid is high.
REQ-031 Error responses (SLVERR/DECERR) SHALL complete the transaction; there is no retry.
REQ-032 Minimum latency is grant T, valid T+1, response at T+2 with zero-wait slave; the next grant is at the earliest the cycle after the return to IDLE.
REQ-033 instr_req_o is never routed to the write path.

Reset
REQ-034 While reset==0 at a clk edge: state<=IDLE, round-robin pointer set to instruction, all outputs 0 (including Read_Data and rsp_err); an in-flight transaction is abandoned with no rvalid pulse.

Verification
REQ-035 instr read at 0x100, ARready=1, Rvalid next cycle with Rdata=0xDEADBEEF and Rresp=0 -> instr_gnt_i at T, ARvalid at T+1, instr_rvalid_i at T+2, Read_Data=0xDEADBEEF, rsp_err=0.
REQ-036 instr and data requests both high for three consecutive transactions -> grants alternate instr, data, instr.
REQ-037 write 0x12345678 with be=4'b0011, AWready 2 cycles before Wready -> AWvalid drops first, Wstrb=0011 throughout, data_rvalid_i after Bvalid.
REQ-038 data read answered with Rresp=2'b10 -> data_rvalid_i=1, rsp_err=1, state back to IDLE.
REQ-039 reset=0 in R_WAIT -> next cycle all outputs 0, no rvalid pulse; a new request after reset is served normally.

Source files
------------

// File: rtl/axi4_lite_dual_master.sv
// AXI4-Lite master shared by an instruction fetch port and a data port.
// Round-robin arbitration, one outstanding transaction at a time.
module axi4_lite_dual_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_req_o,
    input  logic [ADDR_WIDTH-1:0]     instr_addr,
    output logic                      instr_gnt_i,
    output logic                      instr_rvalid_i,
    input  logic                      data_req_o,
    input  logic                      data_we_o,
    input  logic [DATA_WIDTH/8-1:0]   data_be,
    input  logic [ADDR_WIDTH-1:0]     data_addr,
    input  logic [DATA_WIDTH-1:0]     data_wdata,
    output logic                      data_gnt_i,
    output logic                      data_rvalid_i,
    output logic [DATA_WIDTH-1:0]     Read_Data,
    output logic                      rsp_err,
    output logic                      AWvalid,
    input  logic                      AWready,
    output logic [ADDR_WIDTH-1:0]     AWaddr,
    output logic                      Wvalid,
    input  logic                      Wready,
    output logic [DATA_WIDTH-1:0]     Wdata,
    output logic [DATA_WIDTH/8-1:0]   Wstrb,
    input  logic                      Bvalid,
    output logic                      Bready,
    input  logic [1:0]                Bresp,
    output logic                      ARvalid,
    input  logic                      ARready,
    output logic [ADDR_WIDTH-1:0]     ARaddr,
    input  logic                      Rvalid,
    output logic                      Rready,
    input  logic [DATA_WIDTH-1:0]     Rdata,
    input  logic [1:0]                Rresp
);

    localparam int BE_W = DATA_WIDTH / 8;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] AR_WAIT = 3'd1;
    localparam logic [2:0] R_WAIT  = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] B_WAIT  = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  prio_data_q, prio_data_d;
    logic                  src_data_q, src_data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic                  aw_pend_q, aw_pend_d;
    logic                  w_pend_q, w_pend_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic grant_instr;
    logic grant_data;
    logic r_done;
    logic b_done;

    // Grants and completions are gated by reset so nothing fires in a reset cycle.
    always_comb begin
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        if (reset && state_q == IDLE) begin
            if (instr_req_o && data_req_o) begin
                grant_data  = prio_data_q;
                grant_instr = !prio_data_q;
            end else begin
                grant_instr = instr_req_o;
                grant_data  = data_req_o;
            end
        end
        r_done = reset && (state_q == R_WAIT) && Rvalid;
        b_done = reset && (state_q == B_WAIT) && Bvalid;
    end

    always_comb begin
        state_d     = state_q;
        prio_data_d = prio_data_q;
        src_data_d  = src_data_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        read_data_d = read_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_instr) begin
                    src_data_d  = 1'b0;
                    addr_d      = instr_addr;
                    prio_data_d = 1'b1;
                    state_d     = AR_WAIT;
                end else if (grant_data) begin
                    src_data_d  = 1'b1;
                    addr_d      = data_addr;
                    wdata_d     = data_wdata;
                    be_d        = data_be;
                    prio_data_d = 1'b0;
                    if (data_we_o) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = WR_WAIT;
                    end else begin
                        state_d = AR_WAIT;
                    end
                end
            end
            AR_WAIT: begin
                if (ARready) state_d = R_WAIT;
            end
            R_WAIT: begin
                if (Rvalid) begin
                    read_data_d = Rdata;
                    rsp_err_d   = (Rresp != 2'b00);
                    state_d     = IDLE;
                end
            end
            WR_WAIT: begin
                // Address and data channels retire independently, possibly in the same cycle.
                aw_pend_d = aw_pend_q && !AWready;
                w_pend_d  = w_pend_q && !Wready;
                if (!aw_pend_d && !w_pend_d) state_d = B_WAIT;
            end
            B_WAIT: begin
                if (Bvalid) begin
                    rsp_err_d = (Bresp != 2'b00);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            prio_data_q <= 1'b0;
            src_data_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            read_data_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_data_q <= prio_data_d;
            src_data_q  <= src_data_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            read_data_q <= read_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign instr_gnt_i    = grant_instr;
    assign data_gnt_i     = grant_data;
    assign instr_rvalid_i = r_done && !src_data_q;
    assign data_rvalid_i  = b_done || (r_done && src_data_q);

    // Completion data/status are forwarded in the completion cycle, then held.
    assign Read_Data = r_done ? Rdata : read_data_q;
    assign rsp_err   = r_done ? (Rresp != 2'b00) : (b_done ? (Bresp != 2'b00) : rsp_err_q);

    assign ARvalid = (state_q == AR_WAIT);
    assign ARaddr  = addr_q;
    assign Rready  = (state_q == R_WAIT);
    assign AWvalid = aw_pend_q;
    assign AWaddr  = addr_q;
    assign Wvalid  = w_pend_q;
    assign Wdata   = wdata_q;
    assign Wstrb   = be_q;
    assign Bready  = (state_q == B_WAIT);

endmodule

// File: tb/tb_axi4_lite_dual_master.sv
// Self-checking bench for axi4_lite_dual_master: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_axi4_lite_dual_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_req_o;
    logic [31:0] instr_addr;
    logic        instr_gnt_i, instr_rvalid_i;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] Read_Data;
    logic        rsp_err;
    logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
    logic        ARvalid, ARready, Rvalid, Rready;
    logic [31:0] AWaddr, Wdata, ARaddr, Rdata;
    logic [3:0]  Wstrb;
    logic [1:0]  Bresp, Rresp;
    logic [141:0] outs;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: round-robin preference and the last completion status.
    bit          m_prefer_data;
    logic [31:0] m_read_data;
    bit          m_rsp_err;

    axi4_lite_dual_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .instr_req_o(instr_req_o), .instr_addr(instr_addr),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .Read_Data(Read_Data), .rsp_err(rsp_err),
        .AWvalid(AWvalid), .AWready(AWready), .AWaddr(AWaddr),
        .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
        .Bvalid(Bvalid), .Bready(Bready), .Bresp(Bresp),
        .ARvalid(ARvalid), .ARready(ARready), .ARaddr(ARaddr),
        .Rvalid(Rvalid), .Rready(Rready), .Rdata(Rdata), .Rresp(Rresp)
    );

    assign outs = {instr_gnt_i, instr_rvalid_i, data_gnt_i, data_rvalid_i, Read_Data, rsp_err,
                   AWvalid, AWaddr, Wvalid, Wdata, Wstrb, Bready, ARvalid, ARaddr, Rready};

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req_o = 1'b0; instr_addr = '0;
        data_req_o = 1'b0; data_we_o = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
        AWready = 1'b0; Wready = 1'b0; Bvalid = 1'b0; Bresp = 2'b00;
        ARready = 1'b0; Rvalid = 1'b0; Rdata = '0; Rresp = 2'b00;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        m_prefer_data = 1'b0;
        m_read_data   = '0;
        m_rsp_err     = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        instr_req_o = 1'b1;
        data_req_o  = 1'b1;
        tick();
        #1;
        n_vec++;
        if ({instr_gnt_i, data_gnt_i} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL reset_gnt: got %b expected 00", {instr_gnt_i, data_gnt_i});
        end
        tick();
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("[TB] FAIL post_reset_idle: got %h expected 0", outs);
        end
    endtask

    task automatic test_instr_read();
        apply_reset();
        instr_req_o = 1'b1; instr_addr = 32'h100; ARready = 1'b1;
        #1;
        n_vec++;
        if ({instr_gnt_i, data_gnt_i, ARvalid} !== 3'b100) begin
            n_err++;
            $display("[TB] FAIL ir_grant_T: got %b expected 100", {instr_gnt_i, data_gnt_i, ARvalid});
        end
        tick();
        instr_req_o = 1'b0;
        #1;
        n_vec++;
        if ({ARvalid, ARaddr, instr_gnt_i} !== {1'b1, 32'h100, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL ir_arvalid_T1: got %b/%h expected 1/00000100", ARvalid, ARaddr);
        end
        tick();
        ARready = 1'b0; Rvalid = 1'b1; Rdata = 32'hDEADBEEF; Rresp = 2'b00;
        #1;
        n_vec++;
        if ({instr_rvalid_i, data_rvalid_i, Rready, rsp_err, Read_Data} !== {4'b1010, 32'hDEADBEEF}) begin
            n_err++;
            $display("[TB] FAIL ir_complete_T2: got %b%b%b%b %h expected 1010 deadbeef",
                     instr_rvalid_i, data_rvalid_i, Rready, rsp_err, Read_Data);
        end
        tick();
        Rvalid = 1'b0;
        #1;
        n_vec++;
        if ({instr_rvalid_i, Read_Data} !== {1'b0, 32'hDEADBEEF}) begin
            n_err++;
            $display("[TB] FAIL ir_hold_T3: got %b %h expected 0 deadbeef", instr_rvalid_i, Read_Data);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt;
        logic [31:0] exp_addr;
        apply_reset();
        instr_req_o = 1'b1; instr_addr = 32'h200;
        data_req_o  = 1'b1; data_we_o = 1'b0; data_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            exp_gnt  = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_addr = (i % 2 == 0) ? 32'h200 : 32'h300;
            #1;
            n_vec++;
            if ({instr_gnt_i, data_gnt_i} !== exp_gnt) begin
                n_err++;
                $display("[TB] FAIL rr_grant_%0d: got %b expected %b", i, {instr_gnt_i, data_gnt_i}, exp_gnt);
            end
            tick();
            ARready = 1'b1;
            #1;
            n_vec++;
            if ({ARvalid, ARaddr} !== {1'b1, exp_addr}) begin
                n_err++;
                $display("[TB] FAIL rr_araddr_%0d: got %b/%h expected 1/%h", i, ARvalid, ARaddr, exp_addr);
            end
            tick();
            ARready = 1'b0; Rvalid = 1'b1; Rdata = 32'(i);
            #1;
            n_vec++;
            if ({instr_rvalid_i, data_rvalid_i} !== exp_gnt) begin
                n_err++;
                $display("[TB] FAIL rr_rvalid_%0d: got %b expected %b", i, {instr_rvalid_i, data_rvalid_i}, exp_gnt);
            end
            tick();
            Rvalid = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_write_stagger();
        apply_reset();
        data_req_o = 1'b1; data_we_o = 1'b1; data_be = 4'b0011;
        data_addr = 32'h40; data_wdata = 32'h12345678;
        #1;
        n_vec++;
        if ({instr_gnt_i, data_gnt_i} !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL wr_grant: got %b expected 01", {instr_gnt_i, data_gnt_i});
        end
        tick();
        data_req_o = 1'b0;
        for (int c = 0; c < 3; c++) begin
            AWready = (c == 0);
            Wready  = (c == 2);
            #1;
            n_vec++;
            if ({AWvalid, Wvalid, Wstrb, Wdata, AWaddr} !== {(c == 0), 1'b1, 4'b0011, 32'h12345678, 32'h40}) begin
                n_err++;
                $display("[TB] FAIL wr_channels_c%0d: got aw=%b w=%b strb=%b data=%h addr=%h expected aw=%b w=1 strb=0011 data=12345678 addr=40",
                         c, AWvalid, Wvalid, Wstrb, Wdata, AWaddr, (c == 0));
            end
            tick();
        end
        AWready = 1'b0; Wready = 1'b0;
        #1;
        n_vec++;
        if ({Bready, AWvalid, Wvalid, data_rvalid_i} !== 4'b1000) begin
            n_err++;
            $display("[TB] FAIL wr_bwait: got %b expected 1000", {Bready, AWvalid, Wvalid, data_rvalid_i});
        end
        tick();
        Bvalid = 1'b1; Bresp = 2'b00;
        #1;
        n_vec++;
        if ({data_rvalid_i, instr_rvalid_i, rsp_err, Read_Data} !== {3'b100, 32'h0}) begin
            n_err++;
            $display("[TB] FAIL wr_complete: got %b%b%b %h expected 100 00000000",
                     data_rvalid_i, instr_rvalid_i, rsp_err, Read_Data);
        end
        tick();
        Bvalid = 1'b0;
    endtask

    task automatic test_read_error();
        apply_reset();
        data_req_o = 1'b1; data_we_o = 1'b0; data_addr = 32'h80;
        #1;
        n_vec++;
        if (data_gnt_i !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL err_grant: got %b expected 1", data_gnt_i);
        end
        tick();
        data_req_o = 1'b0; ARready = 1'b1;
        tick();
        ARready = 1'b0; Rvalid = 1'b1; Rresp = 2'b10; Rdata = $urandom;
        #1;
        n_vec++;
        if ({data_rvalid_i, instr_rvalid_i, rsp_err} !== 3'b101) begin
            n_err++;
            $display("[TB] FAIL err_complete: got %b expected 101", {data_rvalid_i, instr_rvalid_i, rsp_err});
        end
        tick();
        Rvalid = 1'b0; Rresp = 2'b00;
        instr_req_o = 1'b1; instr_addr = 32'h4;
        #1;
        n_vec++;
        if ({instr_gnt_i, rsp_err, data_rvalid_i} !== 3'b110) begin
            n_err++;
            $display("[TB] FAIL err_back_to_idle: got %b expected 110", {instr_gnt_i, rsp_err, data_rvalid_i});
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        instr_req_o = 1'b1; instr_addr = 32'h10;
        tick();
        instr_req_o = 1'b0; ARready = 1'b1;
        tick();
        ARready = 1'b0;
        #1;
        n_vec++;
        if (Rready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rst_mid_rwait: got %b expected 1", Rready);
        end
        tick();
        reset = 1'b0; Rvalid = 1'b1; Rdata = 32'h0000CAFE;
        #1;
        n_vec++;
        if ({instr_rvalid_i, data_rvalid_i} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL rst_mid_no_pulse: got %b expected 00", {instr_rvalid_i, data_rvalid_i});
        end
        tick();
        reset = 1'b1; Rvalid = 1'b0;
        #1;
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("[TB] FAIL rst_mid_outputs: got %h expected 0", outs);
        end
        tick();
        instr_req_o = 1'b1; instr_addr = 32'h20;
        #1;
        n_vec++;
        if (instr_gnt_i !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rst_mid_regrant: got %b expected 1", instr_gnt_i);
        end
        tick();
        instr_req_o = 1'b0; ARready = 1'b1;
        tick();
        ARready = 1'b0; Rvalid = 1'b1; Rdata = 32'h000055AA; Rresp = 2'b00;
        #1;
        n_vec++;
        if ({instr_rvalid_i, rsp_err, Read_Data} !== {2'b10, 32'h000055AA}) begin
            n_err++;
            $display("[TB] FAIL rst_mid_reread: got %b%b %h expected 10 000055aa", instr_rvalid_i, rsp_err, Read_Data);
        end
        tick();
        Rvalid = 1'b0;
    endtask

    task automatic test_random();
        bit          i_pend, d_pend, win_data, is_write;
        logic [31:0] i_a, d_a, d_wd, t_addr, t_wdata, rd;
        logic [3:0]  d_b, t_be;
        bit          d_w;
        int          ar_d, r_d, aw_d, w_d, b_d, last;
        logic [1:0]  resp;
        apply_reset();
        i_pend = 1'b0; d_pend = 1'b0;
        i_a = '0; d_a = '0; d_wd = '0; d_b = '0; d_w = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend = 1'b1; i_a = $urandom;
            end
            if (!d_pend && $urandom_range(0, 1) == 1) begin
                d_pend = 1'b1; d_a = $urandom; d_wd = $urandom; d_b = 4'($urandom); d_w = 1'($urandom);
            end
            if (!i_pend && !d_pend) begin
                i_pend = 1'b1; i_a = $urandom;
            end
            instr_req_o = i_pend; instr_addr = i_a;
            data_req_o = d_pend; data_addr = d_a; data_wdata = d_wd; data_be = d_b; data_we_o = d_w;
            win_data = (i_pend && d_pend) ? m_prefer_data : d_pend;
            #1;
            n_vec++;
            if ({instr_gnt_i, data_gnt_i, Read_Data, rsp_err} !== {!win_data, win_data, m_read_data, m_rsp_err}) begin
                n_err++;
                $display("[TB] FAIL rnd_grant_%0d: got gnt=%b%b rd=%h err=%b expected gnt=%b%b rd=%h err=%b",
                         n, instr_gnt_i, data_gnt_i, Read_Data, rsp_err, !win_data, win_data, m_read_data, m_rsp_err);
            end
            m_prefer_data = !win_data;
            is_write = win_data && d_w;
            t_addr = win_data ? d_a : i_a;
            t_wdata = d_wd; t_be = d_b;
            if (win_data) d_pend = 1'b0; else i_pend = 1'b0;
            tick();
            instr_req_o = i_pend; data_req_o = d_pend;
            if (!is_write) begin
                ar_d = $urandom_range(0, 2);
                for (int c = 0; c <= ar_d; c++) begin
                    ARready = (c == ar_d);
                    #1;
                    n_vec++;
                    if ({ARvalid, ARaddr, instr_gnt_i, data_gnt_i} !== {1'b1, t_addr, 2'b00}) begin
                        n_err++;
                        $display("[TB] FAIL rnd_ar_%0d: got %b/%h gnt=%b%b expected 1/%h gnt=00",
                                 n, ARvalid, ARaddr, instr_gnt_i, data_gnt_i, t_addr);
                    end
                    tick();
                end
                ARready = 1'b0;
                r_d = $urandom_range(0, 2);
                for (int c = 0; c <= r_d; c++) begin
                    Rvalid = (c == r_d);
                    rd = $urandom; resp = 2'($urandom);
                    Rdata = rd; Rresp = resp;
                    #1;
                    if (c == r_d) begin
                        m_read_data = rd;
                        m_rsp_err = (resp != 2'b00);
                    end
                    n_vec++;
                    if ({Rready, instr_rvalid_i, data_rvalid_i, Read_Data, rsp_err} !==
                        {1'b1, (c == r_d) && !win_data, (c == r_d) && win_data, m_read_data, m_rsp_err}) begin
                        n_err++;
                        $display("[TB] FAIL rnd_r_%0d_%0d: got rr=%b rv=%b%b rd=%h err=%b expected rv=%b%b rd=%h err=%b",
                                 n, c, Rready, instr_rvalid_i, data_rvalid_i, Read_Data, rsp_err,
                                 (c == r_d) && !win_data, (c == r_d) && win_data, m_read_data, m_rsp_err);
                    end
                    tick();
                end
                Rvalid = 1'b0;
            end else begin
                aw_d = $urandom_range(0, 3);
                w_d  = $urandom_range(0, 3);
                last = (aw_d > w_d) ? aw_d : w_d;
                for (int c = 0; c <= last; c++) begin
                    AWready = (c == aw_d);
                    Wready  = (c == w_d);
                    #1;
                    n_vec++;
                    if ({AWvalid, Wvalid, AWaddr, Wdata, Wstrb} !== {(c <= aw_d), (c <= w_d), t_addr, t_wdata, t_be}) begin
                        n_err++;
                        $display("[TB] FAIL rnd_w_%0d_%0d: got aw=%b w=%b %h %h %b expected aw=%b w=%b %h %h %b",
                                 n, c, AWvalid, Wvalid, AWaddr, Wdata, Wstrb,
                                 (c <= aw_d), (c <= w_d), t_addr, t_wdata, t_be);
                    end
                    tick();
                end
                AWready = 1'b0; Wready = 1'b0;
                b_d = $urandom_range(0, 2);
                for (int c = 0; c <= b_d; c++) begin
                    Bvalid = (c == b_d);
                    resp = 2'($urandom);
                    Bresp = resp;
                    #1;
                    if (c == b_d) m_rsp_err = (resp != 2'b00);
                    n_vec++;
                    if ({Bready, data_rvalid_i, instr_rvalid_i, rsp_err, Read_Data} !==
                        {1'b1, (c == b_d), 1'b0, m_rsp_err, m_read_data}) begin
                        n_err++;
                        $display("[TB] FAIL rnd_b_%0d_%0d: got br=%b dv=%b iv=%b err=%b rd=%h expected dv=%b err=%b rd=%h",
                                 n, c, Bready, data_rvalid_i, instr_rvalid_i, rsp_err, Read_Data,
                                 (c == b_d), m_rsp_err, m_read_data);
                    end
                    tick();
                end
                Bvalid = 1'b0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_instr_read();
        test_round_robin();
        test_write_stagger();
        test_read_error();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
